// File: rtl/axis_checker_pkg.sv
// -----------------------------------------------------------------------------
// axis_checker_pkg
// Shared definitions for the AXI-Stream protocol checker:
//   ERR_W         - width of the sticky error vector
//   ERR_*         - bit position of each violation inside err_status
//   clampWidth()  - max(1, w), used to size optional sideband ports
// -----------------------------------------------------------------------------
package axis_checker_pkg;

    localparam int ERR_W = 6;

    localparam int ERR_VALID_DROP        = 0;
    localparam int ERR_PAYLOAD_UNSTABLE  = 1;
    localparam int ERR_VALID_AFTER_RESET = 2;
    localparam int ERR_STRB_WITHOUT_KEEP = 3;
    localparam int ERR_PKT_TOO_LONG      = 4;
    localparam int ERR_STALL_TIMEOUT     = 5;

    // A zero-width sideband still gets a 1-bit port so the port list never
    // collapses; the logic ignores that bit.
    function automatic int clampWidth(input int w);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/axis_popcount.sv
// -----------------------------------------------------------------------------
// axis_popcount
// Purely combinational count of set bits in a TKEEP vector.
// Ports:
//   i_keep   in  BYTE_WIDTH               byte-enable vector
//   o_count  out $clog2(BYTE_WIDTH+1)     number of ones in i_keep
// -----------------------------------------------------------------------------
module axis_popcount #(
    parameter int BYTE_WIDTH = 4
) (
    input  logic [BYTE_WIDTH-1:0]            i_keep,
    output logic [$clog2(BYTE_WIDTH+1)-1:0]  o_count
);

    localparam int CNT_W = $clog2(BYTE_WIDTH + 1);

    // Simple ripple sum; BYTE_WIDTH is small, so a tree buys nothing.
    always_comb begin
        o_count = '0;
        for (int i = 0; i < BYTE_WIDTH; i++) begin
            o_count = o_count + CNT_W'(i_keep[i]);
        end
    end

endmodule

// File: rtl/axis_stream_checker.sv
// -----------------------------------------------------------------------------
// axis_stream_checker
// Passive AXI-Stream protocol checker and traffic counter. Snoops one link,
// never drives it. Flags handshake/stability/reset/length/stall violations
// into a sticky error register and keeps saturating beat/byte/packet counts.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   tvalid, tready, tlast      snooped handshake
//   tdata, tstrb, tkeep        snooped payload and byte qualifiers
//   tid, tdest, tuser          snooped sidebands (1 bit wide when unused)
//   err_clear                  clears err_status
//   cnt_clear                  clears counters and packet tracking
//   err_status [5:0]           sticky violation bits (see axis_checker_pkg)
//   err_pulse                  one-cycle flag for any newly detected violation
//   beat_count, byte_count,
//   packet_count               saturating traffic counters
//   in_packet                  a packet is open (started, TLAST not yet seen)
//
// Build option:
//   AXIS_STREAM_CHECKER_FORMAL_EN - also emit each violation as an immediate
//   assertion so the block can serve as a formal bus checker.
// -----------------------------------------------------------------------------
module axis_stream_checker
    import axis_checker_pkg::*;
#(
    parameter int BYTE_WIDTH    = 4,
    parameter int ID_WIDTH      = 0,
    parameter int DEST_WIDTH    = 0,
    parameter int USER_WIDTH    = 0,
    parameter int COUNT_WIDTH   = 32,
    parameter int MAX_PKT_BEATS = 0,
    parameter int STALL_LIMIT   = 0
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 tvalid,
    input  logic                                 tready,
    input  logic                                 tlast,
    input  logic [8*BYTE_WIDTH-1:0]              tdata,
    input  logic [BYTE_WIDTH-1:0]                tstrb,
    input  logic [BYTE_WIDTH-1:0]                tkeep,
    input  logic [clampWidth(ID_WIDTH)-1:0]      tid,
    input  logic [clampWidth(DEST_WIDTH)-1:0]    tdest,
    input  logic [clampWidth(USER_WIDTH)-1:0]    tuser,
    input  logic                                 err_clear,
    input  logic                                 cnt_clear,
    output logic [ERR_W-1:0]                     err_status,
    output logic                                 err_pulse,
    output logic [COUNT_WIDTH-1:0]               beat_count,
    output logic [COUNT_WIDTH-1:0]               byte_count,
    output logic [COUNT_WIDTH-1:0]               packet_count,
    output logic                                 in_packet
);

    localparam int ID_W    = clampWidth(ID_WIDTH);
    localparam int DEST_W  = clampWidth(DEST_WIDTH);
    localparam int USER_W  = clampWidth(USER_WIDTH);
    localparam int PAY_W   = 10*BYTE_WIDTH + 1 + ID_W + DEST_W + USER_W;
    localparam int POP_W   = $clog2(BYTE_WIDTH + 1);
    localparam int SUM_W   = COUNT_WIDTH + POP_W;
    localparam int PKT_W   = (MAX_PKT_BEATS > 0) ? $clog2(MAX_PKT_BEATS + 1) : 1;
    localparam int STALL_W = (STALL_LIMIT > 0) ? $clog2(STALL_LIMIT + 1) : 1;
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

    logic                    w_hs;
    logic                    w_stall;
    logic [ID_W-1:0]         w_tidCap;
    logic [DEST_W-1:0]       w_tdestCap;
    logic [USER_W-1:0]       w_tuserCap;
    logic [PAY_W-1:0]        w_payload;
    logic [POP_W-1:0]        w_keepCount;
    logic [ERR_W-1:0]        w_viol;

    logic                    r_firstCycle;
    logic                    r_prevValid;
    logic                    r_prevReady;
    logic [PAY_W-1:0]        r_prevPayload;

    logic [ERR_W-1:0]        r_errStatus;
    logic                    r_errPulse;

    logic [STALL_W-1:0]      r_stallCnt;
    logic [STALL_W-1:0]      w_stallCntNext;
    logic [PKT_W-1:0]        r_pktBeats;
    logic [PKT_W-1:0]        w_pktBeatsNext;
    logic                    r_inPacket;
    logic                    w_inPacketNext;

    logic [COUNT_WIDTH-1:0]  r_beatCount;
    logic [COUNT_WIDTH-1:0]  r_byteCount;
    logic [COUNT_WIDTH-1:0]  r_packetCount;
    logic [COUNT_WIDTH-1:0]  w_beatNext;
    logic [COUNT_WIDTH-1:0]  w_byteNext;
    logic [COUNT_WIDTH-1:0]  w_packetNext;

    // Adds without wrapping: the sum is formed wide enough that it cannot
    // overflow, then clamped to all-ones.
    function automatic logic [COUNT_WIDTH-1:0] satAdd(
        input logic [COUNT_WIDTH-1:0] a,
        input logic [POP_W-1:0]       b
    );
        logic [SUM_W-1:0] s;
        s = SUM_W'(a) + SUM_W'(b);
        return (s > SUM_W'(CNT_MAX)) ? CNT_MAX : s[COUNT_WIDTH-1:0];
    endfunction

    assign w_hs    = tvalid && tready;
    assign w_stall = tvalid && !tready;

    // Unused sidebands are forced to zero so they never trip the stability check.
    assign w_tidCap   = (ID_WIDTH   != 0) ? tid   : '0;
    assign w_tdestCap = (DEST_WIDTH != 0) ? tdest : '0;
    assign w_tuserCap = (USER_WIDTH != 0) ? tuser : '0;
    assign w_payload  = {tdata, tstrb, tkeep, tlast, w_tidCap, w_tdestCap, w_tuserCap};

    axis_popcount #(
        .BYTE_WIDTH (BYTE_WIDTH)
    ) u_popcount (
        .i_keep  (tkeep),
        .o_count (w_keepCount)
    );

    // Violation detection for the current cycle. The stall bit fires only on
    // the cycle the run reaches the limit; afterwards the counter sits
    // saturated at the limit, so it cannot match LIMIT-1 again in that run.
    always_comb begin
        w_viol = '0;
        w_viol[ERR_VALID_DROP]        = !r_firstCycle && !tvalid && r_prevValid && !r_prevReady;
        w_viol[ERR_PAYLOAD_UNSTABLE]  = !r_firstCycle && r_prevValid && !r_prevReady &&
                                        (w_payload != r_prevPayload);
        w_viol[ERR_VALID_AFTER_RESET] = r_firstCycle && tvalid;
        w_viol[ERR_STRB_WITHOUT_KEEP] = tvalid && ((tstrb & ~tkeep) != '0);
        w_viol[ERR_PKT_TOO_LONG]      = (MAX_PKT_BEATS != 0) && w_hs &&
                                        (r_pktBeats == PKT_W'(MAX_PKT_BEATS));
        w_viol[ERR_STALL_TIMEOUT]     = (STALL_LIMIT != 0) && w_stall &&
                                        (r_stallCnt == STALL_W'(STALL_LIMIT - 1));
    end

    // Next values of the stall run, packet tracking and traffic counters.
    // cnt_clear takes priority over a same-cycle handshake.
    always_comb begin
        w_stallCntNext = '0;
        w_beatNext     = r_beatCount;
        w_byteNext     = r_byteCount;
        w_packetNext   = r_packetCount;
        w_pktBeatsNext = r_pktBeats;
        w_inPacketNext = r_inPacket;

        if (w_stall) begin
            w_stallCntNext = (r_stallCnt == STALL_W'(STALL_LIMIT)) ? r_stallCnt
                                                                   : r_stallCnt + STALL_W'(1);
        end

        if (cnt_clear) begin
            w_beatNext     = '0;
            w_byteNext     = '0;
            w_packetNext   = '0;
            w_pktBeatsNext = '0;
            w_inPacketNext = 1'b0;
        end else if (w_hs) begin
            w_beatNext = satAdd(r_beatCount, POP_W'(1));
            w_byteNext = satAdd(r_byteCount, w_keepCount);
            if (tlast) begin
                w_packetNext   = satAdd(r_packetCount, POP_W'(1));
                w_pktBeatsNext = '0;
                w_inPacketNext = 1'b0;
            end else begin
                if (r_pktBeats != PKT_W'(MAX_PKT_BEATS)) begin
                    w_pktBeatsNext = r_pktBeats + PKT_W'(1);
                end
                w_inPacketNext = 1'b1;
            end
        end
    end

    // Previous-cycle snapshot used by the drop/stability checks. first_cycle
    // marks the one edge right after reset release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_firstCycle  <= 1'b1;
            r_prevValid   <= 1'b0;
            r_prevReady   <= 1'b0;
            r_prevPayload <= '0;
        end else begin
            r_firstCycle  <= 1'b0;
            r_prevValid   <= tvalid;
            r_prevReady   <= tready;
            r_prevPayload <= w_payload;
        end
    end

    // Sticky error bits. err_clear drops the old bits but keeps whatever is
    // detected in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_errStatus <= '0;
            r_errPulse  <= 1'b0;
        end else begin
            r_errStatus <= err_clear ? w_viol : (r_errStatus | w_viol);
            r_errPulse  <= |w_viol;
        end
    end

    // Counters and packet tracking state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stallCnt    <= '0;
            r_pktBeats    <= '0;
            r_inPacket    <= 1'b0;
            r_beatCount   <= '0;
            r_byteCount   <= '0;
            r_packetCount <= '0;
        end else begin
            r_stallCnt    <= w_stallCntNext;
            r_pktBeats    <= w_pktBeatsNext;
            r_inPacket    <= w_inPacketNext;
            r_beatCount   <= w_beatNext;
            r_byteCount   <= w_byteNext;
            r_packetCount <= w_packetNext;
        end
    end

    assign err_status   = r_errStatus;
    assign err_pulse    = r_errPulse;
    assign beat_count   = r_beatCount;
    assign byte_count   = r_byteCount;
    assign packet_count = r_packetCount;
    assign in_packet    = r_inPacket;

`ifdef AXIS_STREAM_CHECKER_FORMAL_EN
    logic r_pastValid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pastValid <= 1'b0;
        end else begin
            r_pastValid <= 1'b1;
        end
    end

    // The valid-after-reset check lives exactly on the cycle that r_pastValid
    // is still low, so it is gated by reset alone.
    always @(posedge clk) begin
        if (!reset && r_pastValid) begin
            assert (!w_viol[ERR_VALID_DROP]);
            assert (!w_viol[ERR_PAYLOAD_UNSTABLE]);
            assert (!w_viol[ERR_STRB_WITHOUT_KEEP]);
            assert (!w_viol[ERR_PKT_TOO_LONG]);
            assert (!w_viol[ERR_STALL_TIMEOUT]);
        end
        if (!reset) begin
            assert (!w_viol[ERR_VALID_AFTER_RESET]);
        end
    end
`endif

endmodule

// File: tb/tb_axis_stream_checker.sv
// -----------------------------------------------------------------------------
// tb_axis_stream_checker
// Self-checking bench: a directed vector table, hand-written corner-case
// sequences and a randomized phase, all compared against a behavioural model
// that tracks stall-run and packet lengths as plain integers.
// -----------------------------------------------------------------------------
module tb_axis_stream_checker;

    localparam int CW        = 6;
    localparam int SAT       = 63;
    localparam int MAXPKT    = 4;
    localparam int STALL_LIM = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        tvalid, tready, tlast;
    logic [31:0] tdata;
    logic [3:0]  tstrb, tkeep;
    logic [1:0]  tid;
    logic [0:0]  tdest;
    logic [0:0]  tuser;
    logic        err_clear, cnt_clear;
    logic [5:0]  err_status;
    logic        err_pulse;
    logic [CW-1:0] beat_count, byte_count, packet_count;
    logic        in_packet;

    always #5 clk = ~clk;

    axis_stream_checker #(
        .BYTE_WIDTH    (4),
        .ID_WIDTH      (2),
        .DEST_WIDTH    (0),
        .USER_WIDTH    (1),
        .COUNT_WIDTH   (CW),
        .MAX_PKT_BEATS (MAXPKT),
        .STALL_LIMIT   (STALL_LIM)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .tvalid       (tvalid),
        .tready       (tready),
        .tlast        (tlast),
        .tdata        (tdata),
        .tstrb        (tstrb),
        .tkeep        (tkeep),
        .tid          (tid),
        .tdest        (tdest),
        .tuser        (tuser),
        .err_clear    (err_clear),
        .cnt_clear    (cnt_clear),
        .err_status   (err_status),
        .err_pulse    (err_pulse),
        .beat_count   (beat_count),
        .byte_count   (byte_count),
        .packet_count (packet_count),
        .in_packet    (in_packet)
    );

    int testsRun    = 0;
    int testsFailed = 0;

    // Reference model state
    bit          mFirst;
    bit          mPrevValid, mPrevReady;
    logic [63:0] mPrevPay;
    logic [5:0]  mErr;
    bit          mPulse;
    int          mBeat, mByte, mPkt;
    bit          mInPkt;
    int          mRun;
    int          mPktLen;

    typedef struct {
        logic        v, r, last;
        logic [31:0] data;
        logic [3:0]  strb, keep;
        logic        ec, cc;
        logic [5:0]  expErr;
        logic        expPulse;
        int          expBeat, expByte, expPkt;
        logic        expIn;
    } vec_t;

    vec_t tbl[16];

    function automatic vec_t mkVec(logic v, logic r, logic last, logic [31:0] data,
                                   logic [3:0] strb, logic [3:0] keep, logic ec, logic cc,
                                   logic [5:0] eErr, logic ePulse, int eBeat, int eByte,
                                   int ePkt, logic eIn);
        vec_t t;
        t.v = v; t.r = r; t.last = last; t.data = data; t.strb = strb; t.keep = keep;
        t.ec = ec; t.cc = cc; t.expErr = eErr; t.expPulse = ePulse;
        t.expBeat = eBeat; t.expByte = eByte; t.expPkt = ePkt; t.expIn = eIn;
        return t;
    endfunction

    function automatic int sat(int x);
        return (x > SAT) ? SAT : x;
    endfunction

    function automatic logic [63:0] payloadNow();
        return {20'b0, tdata, tstrb, tkeep, tlast, tid, tuser};
    endfunction

    task automatic checkVal(input string name, input longint act, input longint exp);
        testsRun++;
        if (act != exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic modelReset();
        mFirst = 1; mPrevValid = 0; mPrevReady = 0; mPrevPay = '0;
        mErr = '0; mPulse = 0; mBeat = 0; mByte = 0; mPkt = 0;
        mInPkt = 0; mRun = 0; mPktLen = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic modelEdge();
        logic [63:0] pay;
        logic [5:0]  viol;
        bit          hs, stall;
        pay   = payloadNow();
        hs    = tvalid && tready;
        stall = tvalid && !tready;
        viol  = '0;
        if (!mFirst && mPrevValid && !mPrevReady) begin
            if (!tvalid) viol[0] = 1'b1;
            if (pay != mPrevPay) viol[1] = 1'b1;
        end
        if (mFirst && tvalid) viol[2] = 1'b1;
        if (tvalid && ((tstrb & ~tkeep) != 4'h0)) viol[3] = 1'b1;
        if (hs && mPktLen >= MAXPKT) viol[4] = 1'b1;
        if (stall) begin
            mRun++;
            if (mRun == STALL_LIM) viol[5] = 1'b1;
        end else begin
            mRun = 0;
        end
        mErr   = err_clear ? viol : (mErr | viol);
        mPulse = (viol != 6'h0);
        if (cnt_clear) begin
            mBeat = 0; mByte = 0; mPkt = 0; mPktLen = 0; mInPkt = 0;
        end else if (hs) begin
            mBeat = sat(mBeat + 1);
            mByte = sat(mByte + $countones(tkeep));
            if (tlast) begin
                mPkt = sat(mPkt + 1); mPktLen = 0; mInPkt = 0;
            end else begin
                mPktLen++; mInPkt = 1;
            end
        end
        mFirst = 0; mPrevValid = tvalid; mPrevReady = tready; mPrevPay = pay;
    endtask

    task automatic setIdle();
        tvalid = 0; tready = 0; tlast = 0; tdata = '0; tstrb = '0; tkeep = '0;
        tid = '0; tdest = '0; tuser = '0; err_clear = 0; cnt_clear = 0;
    endtask

    task automatic drive(input logic v, input logic r, input logic last,
                         input logic [31:0] data, input logic [3:0] strb, input logic [3:0] keep);
        tvalid = v; tready = r; tlast = last; tdata = data; tstrb = strb; tkeep = keep;
    endtask

    task automatic applyStimulus();
        modelEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput();
        checkVal("err_status",   err_status,   mErr);
        checkVal("err_pulse",    err_pulse,    mPulse);
        checkVal("beat_count",   beat_count,   mBeat);
        checkVal("byte_count",   byte_count,   mByte);
        checkVal("packet_count", packet_count, mPkt);
        checkVal("in_packet",    in_packet,    mInPkt);
    endtask

    // Asserts reset between clock edges and checks the outputs clear at once.
    task automatic doReset();
        reset = 1'b1;
        #2;
        checkVal("reset err_status",   err_status,   0);
        checkVal("reset err_pulse",    err_pulse,    0);
        checkVal("reset beat_count",   beat_count,   0);
        checkVal("reset byte_count",   byte_count,   0);
        checkVal("reset packet_count", packet_count, 0);
        checkVal("reset in_packet",    in_packet,    0);
        modelReset();
        setIdle();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic step();
        applyStimulus();
        checkOutput();
    endtask

    initial begin
        setIdle();
        tbl[0]  = mkVec(0,0,0,32'h0,        4'h0,4'h0,0,0, 6'h00,0, 0, 0,0,0);
        tbl[1]  = mkVec(1,1,0,32'h11111111, 4'hF,4'hF,0,0, 6'h00,0, 1, 4,0,1);
        tbl[2]  = mkVec(1,1,0,32'h22222222, 4'hF,4'hF,0,0, 6'h00,0, 2, 8,0,1);
        tbl[3]  = mkVec(1,1,1,32'h33333333, 4'hF,4'hF,0,0, 6'h00,0, 3,12,1,0);
        tbl[4]  = mkVec(1,0,0,32'hA5A5A5A5, 4'hF,4'hF,0,0, 6'h00,0, 3,12,1,0);
        tbl[5]  = mkVec(1,0,0,32'h5A5A5A5A, 4'hF,4'hF,0,0, 6'h02,1, 3,12,1,0);
        tbl[6]  = mkVec(1,1,0,32'h5A5A5A5A, 4'hF,4'hF,0,0, 6'h02,0, 4,16,1,1);
        tbl[7]  = mkVec(0,0,0,32'h5A5A5A5A, 4'hF,4'hF,1,0, 6'h00,0, 4,16,1,1);
        tbl[8]  = mkVec(1,0,0,32'h77777777, 4'hF,4'hF,0,0, 6'h00,0, 4,16,1,1);
        tbl[9]  = mkVec(0,0,0,32'h77777777, 4'hF,4'hF,0,0, 6'h01,1, 4,16,1,1);
        tbl[10] = mkVec(0,0,0,32'h77777777, 4'hF,4'hF,0,0, 6'h01,0, 4,16,1,1);
        tbl[11] = mkVec(1,1,1,32'h99999999, 4'h3,4'h1,0,0, 6'h09,1, 5,17,2,0);
        tbl[12] = mkVec(0,0,0,32'h0,        4'h0,4'h0,1,1, 6'h00,0, 0, 0,0,0);
        tbl[13] = mkVec(1,1,0,32'hAAAAAAAA, 4'hF,4'hF,0,1, 6'h00,0, 0, 0,0,0);
        tbl[14] = mkVec(1,1,1,32'hBBBBBBBB, 4'h3,4'h3,0,0, 6'h00,0, 1, 2,1,0);
        tbl[15] = mkVec(0,0,0,32'h0,        4'h0,4'h0,0,0, 6'h00,0, 1, 2,1,0);

        #1;
        doReset();

        // Directed vector table
        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].v, tbl[i].r, tbl[i].last, tbl[i].data, tbl[i].strb, tbl[i].keep);
            err_clear = tbl[i].ec;
            cnt_clear = tbl[i].cc;
            step();
            checkVal($sformatf("vec%0d err_status", i),   err_status,   tbl[i].expErr);
            checkVal($sformatf("vec%0d err_pulse", i),    err_pulse,    tbl[i].expPulse);
            checkVal($sformatf("vec%0d beat_count", i),   beat_count,   tbl[i].expBeat);
            checkVal($sformatf("vec%0d byte_count", i),   byte_count,   tbl[i].expByte);
            checkVal($sformatf("vec%0d packet_count", i), packet_count, tbl[i].expPkt);
            checkVal($sformatf("vec%0d in_packet", i),    in_packet,    tbl[i].expIn);
        end
        setIdle();

        // tvalid high on the very first edge after reset
        doReset();
        drive(1, 1, 1, 32'hDEADBEEF, 4'hF, 4'hF);
        step();
        checkVal("valid_after_reset bit", err_status[2], 1);
        checkVal("valid_after_reset pulse", err_pulse, 1);
        setIdle();
        step();
        checkVal("valid_after_reset pulse gone", err_pulse, 0);

        // Packet longer than MAX_PKT_BEATS
        doReset();
        step();
        for (int k = 1; k <= 5; k++) begin
            drive(1, 1, 0, 32'(k), 4'hF, 4'hF);
            step();
            checkVal($sformatf("pkt_too_long beat%0d", k), err_status[4], (k == 5) ? 1 : 0);
        end
        checkVal("pkt_too_long in_packet", in_packet, 1);
        drive(1, 1, 1, 32'h6, 4'hF, 4'hF);
        step();
        checkVal("pkt_too_long closed", in_packet, 0);
        setIdle();
        step();

        // Stall run reaching STALL_LIMIT, then continuing
        doReset();
        step();
        for (int k = 1; k <= 9; k++) begin
            drive(1, 0, 0, 32'hC0FFEE00, 4'hF, 4'hF);
            step();
            checkVal($sformatf("stall cycle%0d bit", k), err_status[5], (k >= 8) ? 1 : 0);
            checkVal($sformatf("stall cycle%0d pulse", k), err_pulse, (k == 8) ? 1 : 0);
        end
        drive(1, 1, 1, 32'hC0FFEE00, 4'hF, 4'hF);
        step();
        setIdle();
        step();

        // Counter saturation
        doReset();
        step();
        for (int k = 0; k < 70; k++) begin
            drive(1, 1, 1, 32'(k), 4'hF, 4'hF);
            step();
        end
        checkVal("sat beat_count",   beat_count,   SAT);
        checkVal("sat byte_count",   byte_count,   SAT);
        checkVal("sat packet_count", packet_count, SAT);
        setIdle();
        step();

        // Reset dropped in the middle of a packet
        doReset();
        step();
        drive(1, 1, 0, 32'h1, 4'hF, 4'hF);
        step();
        drive(1, 1, 0, 32'h2, 4'hF, 4'hF);
        step();
        checkVal("midpkt in_packet before reset", in_packet, 1);
        doReset();
        step();
        drive(1, 1, 1, 32'h3, 4'hF, 4'hF);
        step();
        checkVal("midpkt new packet_count", packet_count, 1);
        checkVal("midpkt new in_packet", in_packet, 0);
        checkVal("midpkt no too_long", err_status[4], 0);
        setIdle();
        step();

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(399) == 0) begin
                doReset();
            end
            if (!(tvalid && !tready && $urandom_range(9) != 0)) begin
                tvalid = ($urandom_range(9) < 7);
            end
            tready = ($urandom_range(9) < 6);
            if ($urandom_range(4) == 0) begin
                tdata = $urandom;
                tkeep = 4'($urandom_range(15));
                tstrb = ($urandom_range(9) == 0) ? 4'($urandom_range(15)) : tkeep;
                tlast = 1'($urandom_range(1));
                tid   = 2'($urandom_range(3));
                tuser = 1'($urandom_range(1));
            end
            tdest     = 1'($urandom_range(1));
            err_clear = ($urandom_range(19) == 0);
            cnt_clear = ($urandom_range(39) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
